mem_access_seq: RTL and testbench
=================================

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: the MEM-stage instruction requests a data access this cycle.
REQ-004 SHALL have port req_write, input, 1 bit: the final access is a write (STR/STB/STI); 0 means read (LDR/LDB/LDI).
REQ-005 SHALL have port req_indirect, input, 1 bit: two-phase access (LDI/STI); first phase is a pointer read.
REQ-006 SHALL have port req_byte_en, input, 2 bits: byte enables for the final access.
REQ-007 SHALL have port req_addr, input, 16 bits: effective address.
REQ-008 SHALL have port req_wdata, input, 16 bits: store data.
REQ-009 SHALL have port stall, output, 1 bit: holds the pipeline while the access is incomplete.
REQ-010 SHALL have port rdata, output, 16 bits: final read data.
REQ-011 SHALL have port rdata_valid, output, 1 bit: rdata is valid and the transaction is retiring.
REQ-012 SHALL have port dmem_read, output, 1 bit: memory read strobe.
REQ-013 SHALL have port dmem_write, output, 1 bit: memory write strobe.
REQ-014 SHALL have port dmem_byte_enable, output, 2 bits: byte enables to memory.
REQ-015 SHALL have port dmem_address, output, 16 bits: address to memory.
REQ-016 SHALL have port dmem_wdata, output, 16 bits: write data to memory.
REQ-017 SHALL have port dmem_rdata, input, 16 bits: read data from memory.
REQ-018 SHALL have port dmem_resp, input, 1 bit: memory completes the current strobe (one-cycle pulse).

Function
REQ-019 SHALL implement FSM states IDLE, PTR, ACCESS, DONE.
REQ-020 IDLE, req_valid=1: SHALL latch addr, wdata, byte_en, write and indirect.
  - Next state is PTR when req_indirect=1, else ACCESS.
  - stall=1 in that cycle.
REQ-021 PTR SHALL drive the pointer read:
  - dmem_read=1, dmem_byte_enable=2'b11, dmem_address={latched_addr[15:1],1'b0}.
  - On dmem_resp: latch dmem_rdata as the new address, then go to ACCESS.
REQ-022 ACCESS SHALL drive dmem_read=~write and dmem_write=write.
  - Address, byte enables and wdata come from the latches.
  - Word accesses (byte_en=2'b11) force address bit 0 to 0.
REQ-023 ACCESS, on dmem_resp: for a read, SHALL capture dmem_rdata into rdata, then go to DONE.
REQ-024 DONE SHALL last exactly one cycle: rdata_valid=1, stall=0, next state IDLE.
REQ-025 stall SHALL be 1 in IDLE when req_valid=1, and in PTR and ACCESS; 0 otherwise.
REQ-026 dmem strobes SHALL stay asserted and stable until dmem_resp, never asserting in IDLE or DONE.
REQ-027 Latched request fields SHALL ignore input changes while in PTR, ACCESS or DONE.
REQ-028 dmem_read and dmem_write SHALL never be 1 in the same cycle.
REQ-029 A req_valid held high in DONE SHALL NOT start a new transaction until the following IDLE cycle.
REQ-030 dmem_resp arriving in IDLE or DONE SHALL be ignored.
REQ-031 Latency: direct access = 1 + N + 1 cycles; indirect = 1 + N1 + N2 + 1, where N counts cycles up to and including dmem_resp.
REQ-032 rdata SHALL hold its last value until the next read completes; it is not cleared for writes.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock edge:
  - force state IDLE;
  - set stall, rdata_valid, dmem_read and dmem_write to 0;
  - clear rdata, dmem_address and dmem_wdata to 0x0000, with dmem_byte_enable at 2'b00.
REQ-034 Reset mid-transaction SHALL abandon the access; a later dmem_resp SHALL be ignored.

Verification
REQ-035 LDR: addr 0x1234, memory returns 0xBEEF after 2 cycles.
  - Expect dmem_read at 0x1234 with enables 11.
  - Expect rdata=0xBEEF with rdata_valid for 1 cycle, then stall deasserts.
REQ-036 STB: addr 0x2001, be 2'b10, wdata 0xAB00.
  - Expect dmem_write at 0x2001, be 10, wdata 0xAB00, read never asserted.
REQ-037 LDI: addr 0x3000, pointer 0x4000, data 0x5555.
  - Expect a read at 0x3000, then a read at 0x4000, then rdata=0x5555.
  - Expect stall held throughout.
REQ-038 STI: addr 0x3001, pointer 0x4001, wdata 0x1111.
  - Expect a pointer read at 0x3000, then a write at 0x4000 with be 11.
REQ-039 rst_n low during ACCESS with dmem_resp pending.
  - Expect strobes to drop asynchronously and state IDLE.
  - A resp pulse after release changes nothing.
REQ-040 req_valid held high across DONE.
  - Expect no strobe in DONE; the second transaction begins from the next IDLE.

Source files
------------

// File: rtl/mem_access_seq.sv
// Data-memory access sequencer for the MEM stage: runs direct loads/stores and
// two-phase indirect accesses (pointer read, then the final read or write).
module mem_access_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_indirect,
    input  logic [1:0]  req_byte_en,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp
);

    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        write_q, write_d;
    logic        ind_q, ind_d;
    logic [15:0] rdata_q, rdata_d;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others, whatever order the tool evaluates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            write_q <= 1'b0;
            ind_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            ind_q   <= ind_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        write_d          = write_q;
        ind_d            = ind_q;
        rdata_d          = rdata_q;
        stall            = 1'b0;
        rdata_valid      = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_byte_en;
                    write_d = req_write;
                    ind_d   = req_indirect;
                    state_d = req_indirect ? PTR : ACCESS;
                end
            end
            PTR: begin
                // Pointers are always whole aligned words.
                stall            = 1'b1;
                dmem_read        = 1'b1;
                dmem_byte_enable = 2'b11;
                dmem_address     = {addr_q[15:1], 1'b0};
                if (dmem_resp) begin
                    addr_d  = dmem_rdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall            = 1'b1;
                dmem_read        = ~write_q;
                dmem_write       = write_q;
                dmem_byte_enable = be_q;
                dmem_address     = (be_q == 2'b11) ? {addr_q[15:1], 1'b0} : addr_q;
                dmem_wdata       = wdata_q;
                if (dmem_resp) begin
                    if (!write_q) rdata_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_valid = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: a word-addressed memory model decides
// every bus phase, address and read value; the bench plays the memory side.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_indirect;
    logic [1:0]  req_byte_en;
    logic [15:0] req_addr, req_wdata;
    logic        stall, rdata_valid, dmem_read, dmem_write, dmem_resp;
    logic [15:0] rdata, dmem_address, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_byte_enable;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] last_rdata;
    logic [15:0] got_addr, got_ptr, got_rdata;

    mem_access_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_indirect(req_indirect),
        .req_byte_en(req_byte_en), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:1], 1'b0};
        return mem.exists(w) ? mem[w] : 16'h0000;
    endfunction

    task automatic mem_wr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] old;
        old = mem_rd(a);
        mem[{a[15:1], 1'b0}] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endtask

    task automatic scramble_req();
        req_write    = 1'($urandom);
        req_indirect = 1'($urandom);
        req_byte_en  = 2'($urandom);
        req_addr     = 16'($urandom);
        req_wdata    = 16'($urandom);
    endtask

    // One cycle with no request pending: nothing on the bus, rdata held.
    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_stall"}, 16'(stall), 16'h0);
        check({name, "_strobes"}, {14'h0, dmem_read, dmem_write}, 16'h0);
        check({name, "_rvalid"}, 16'(rdata_valid), 16'h0);
        check({name, "_rdata"}, rdata, last_rdata);
        @(posedge clk); #1;
    endtask

    // Runs one transaction from an IDLE cycle; n1/n2 are the pointer and final
    // phase latencies (cycles up to and including the response).
    task automatic run_txn(input string name, input logic wr, input logic ind,
                           input logic [1:0] be, input logic [15:0] addr,
                           input logic [15:0] wdata, input int n1, input int n2,
                           input logic hold);
        logic [15:0] ptr_addr, fin, exp_rd;
        ptr_addr = {addr[15:1], 1'b0};
        fin      = ind ? mem_rd(ptr_addr) : addr;
        if (be == 2'b11) fin[0] = 1'b0;
        exp_rd   = wr ? last_rdata : mem_rd(fin);
        got_ptr  = 16'hxxxx;

        req_valid = 1'b1; req_write = wr; req_indirect = ind;
        req_byte_en = be; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        check({name, "_acc_stall"}, 16'(stall), 16'h1);
        check({name, "_acc_strobes"}, {14'h0, dmem_read, dmem_write}, 16'h0);
        @(posedge clk); #1;
        req_valid = hold;
        scramble_req();

        if (ind) begin
            for (int k = 1; k <= n1; k++) begin
                dmem_resp  = (k == n1);
                dmem_rdata = (k == n1) ? mem_rd(ptr_addr) : 16'($urandom);
                @(negedge clk);
                if (k == 1) got_ptr = dmem_address;
                check({name, "_ptr_strobes"}, {14'h0, dmem_read, dmem_write}, 16'h2);
                check({name, "_ptr_addr"}, dmem_address, ptr_addr);
                check({name, "_ptr_be"}, 16'(dmem_byte_enable), 16'h3);
                check({name, "_ptr_stall"}, 16'(stall), 16'h1);
                @(posedge clk); #1;
                scramble_req();
            end
        end

        for (int k = 1; k <= n2; k++) begin
            dmem_resp  = (k == n2);
            dmem_rdata = (k == n2 && !wr) ? mem_rd(fin) : 16'($urandom);
            @(negedge clk);
            if (k == 1) got_addr = dmem_address;
            check({name, "_strobes"}, {14'h0, dmem_read, dmem_write}, wr ? 16'h1 : 16'h2);
            check({name, "_addr"}, dmem_address, fin);
            check({name, "_be"}, 16'(dmem_byte_enable), 16'(be));
            if (wr) check({name, "_wdata"}, dmem_wdata, wdata);
            check({name, "_stall"}, 16'(stall), 16'h1);
            check({name, "_rv_early"}, 16'(rdata_valid), 16'h0);
            @(posedge clk); #1;
            scramble_req();
        end
        dmem_resp = 1'b0;
        if (wr) mem_wr(fin, be, wdata);

        @(negedge clk);
        check({name, "_done_rv"}, 16'(rdata_valid), 16'h1);
        check({name, "_done_stall"}, 16'(stall), 16'h0);
        check({name, "_done_strobes"}, {14'h0, dmem_read, dmem_write}, 16'h0);
        check({name, "_done_rdata"}, rdata, exp_rd);
        got_rdata  = rdata;
        last_rdata = exp_rd;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
        scramble_req();
        last_rdata = 16'h0000;
        mem[16'h1234] = 16'hBEEF;
        mem[16'h3000] = 16'h4000;
        mem[16'h4000] = 16'h5555;

        #3;
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_strobes", {14'h0, dmem_read, dmem_write}, 16'h0);
        check("rst_rvalid", 16'(rdata_valid), 16'h0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_addr", dmem_address, 16'h0000);
        check("rst_wdata", dmem_wdata, 16'h0000);
        check("rst_be", 16'(dmem_byte_enable), 16'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check("idle0");

        dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        idle_check("resp_in_idle");
        dmem_resp = 1'b0;
        idle_check("idle1");

        run_txn("ldr", 1'b0, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 2, 1'b0);
        check("ldr_lit_addr", got_addr, 16'h1234);
        check("ldr_lit_rdata", got_rdata, 16'hBEEF);
        idle_check("ldr_after");

        run_txn("ldb", 1'b0, 1'b0, 2'b10, 16'h1235, 16'h0, 0, 1, 1'b0);
        check("ldb_lit_addr", got_addr, 16'h1235);

        run_txn("stb", 1'b1, 1'b0, 2'b10, 16'h2001, 16'hAB00, 0, 3, 1'b0);
        check("stb_lit_addr", got_addr, 16'h2001);
        check("stb_lit_rdata_held", got_rdata, 16'hBEEF);

        run_txn("str_odd", 1'b1, 1'b0, 2'b11, 16'h2003, 16'h1357, 0, 1, 1'b0);
        check("str_lit_addr", got_addr, 16'h2002);
        run_txn("ldr_back", 1'b0, 1'b0, 2'b11, 16'h2000, 16'h0, 0, 1, 1'b0);
        check("ldr_back_lit", got_rdata, 16'hAB00);

        run_txn("ldi", 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0, 2, 3, 1'b0);
        check("ldi_lit_ptr", got_ptr, 16'h3000);
        check("ldi_lit_addr", got_addr, 16'h4000);
        check("ldi_lit_rdata", got_rdata, 16'h5555);

        mem[16'h3000] = 16'h4001;
        run_txn("sti", 1'b1, 1'b1, 2'b11, 16'h3001, 16'h1111, 1, 2, 1'b0);
        check("sti_lit_ptr", got_ptr, 16'h3000);
        check("sti_lit_addr", got_addr, 16'h4000);

        run_txn("hold_a", 1'b0, 1'b0, 2'b11, 16'h2002, 16'h0, 0, 1, 1'b1);
        check("hold_a_lit", got_rdata, 16'h1357);
        run_txn("hold_b", 1'b0, 1'b0, 2'b11, 16'h4000, 16'h0, 0, 2, 1'b0);
        check("hold_b_lit", got_rdata, 16'h1111);
        idle_check("hold_after");

        // Abandon a read mid-access with reset, then deliver its stale response.
        req_valid = 1'b1; req_write = 1'b0; req_indirect = 1'b0;
        req_byte_en = 2'b11; req_addr = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_pre_read", 16'(dmem_read), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_strobes", {14'h0, dmem_read, dmem_write}, 16'h0);
        check("rstmid_stall", 16'(stall), 16'h0);
        check("rstmid_addr", dmem_address, 16'h0000);
        check("rstmid_be", 16'(dmem_byte_enable), 16'h0);
        check("rstmid_rdata", rdata, 16'h0000);
        last_rdata = 16'h0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 16'h9999;
        idle_check("rstmid_resp");
        dmem_resp = 1'b0;
        idle_check("rstmid_after");

        run_txn("ldr_post_rst", 1'b0, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 1, 1'b0);
        check("post_rst_lit", got_rdata, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
